// File: rtl/ccp_l2_ingress_if.sv
// Valid/ready message stream carrying one L1.5 coherence message.
interface ccp_l2_ingress_if #(
  parameter int unsigned MSG_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned OWNER_BITS = 3
);
  logic                  valid;
  logic                  ready;
  logic [MSG_WIDTH-1:0]  msg_type;
  logic [DATA_WIDTH-1:0] data;
  logic [TAG_WIDTH-1:0]  tag;
  logic [OWNER_BITS-1:0] source;

  modport master (output valid, msg_type, data, tag, source, input ready);
  modport slave  (input valid, msg_type, data, tag, source, output ready);
endinterface

// File: rtl/ccp_l2_ingress.sv
// L2 ingress: per-channel FIFOs for L1.5 requests (ch1) and responses (ch3),
// merged onto one L2 port with response priority and a starvation guard.
module ccp_l2_ingress #(
  parameter int unsigned MSG_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned TAG_WIDTH    = 8,
  parameter int unsigned OWNER_BITS   = 3,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ccp_l2_ingress_if.slave        msg1,
  ccp_l2_ingress_if.slave        msg3,
  ccp_l2_ingress_if.master       out,
  output logic                   out_chan,
  output logic [$clog2(DEPTH):0] msg1_count,
  output logic [$clog2(DEPTH):0] msg3_count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = MSG_WIDTH + DATA_WIDTH + TAG_WIDTH + OWNER_BITS;

  typedef enum logic {ARB_OPEN, ARB_HELD} arb_state_e;

  // Index 0 = channel 1 (requests), index 1 = channel 3 (responses).
  logic [EW-1:0] mem_q [2][DEPTH];
  logic [EW-1:0] mem_d [2][DEPTH];
  logic [PW-1:0] wp_q [2], wp_d [2];
  logic [PW-1:0] rp_q [2], rp_d [2];
  logic [CW-1:0] cnt_q [2], cnt_d [2];
  logic [7:0]    starve_q, starve_d;
  arb_state_e    state_q, state_d;
  logic          grant_q, grant_d;

  logic [EW-1:0] in_ent [2];
  logic [1:0]    in_valid, nonempty, push, pop;
  logic          out_valid_i, grant, handshake;

  assign in_valid  = {msg3.valid, msg1.valid};
  assign in_ent[0] = {msg1.msg_type, msg1.data, msg1.tag, msg1.source};
  assign in_ent[1] = {msg3.msg_type, msg3.data, msg3.tag, msg3.source};

  assign msg1.ready = (cnt_q[0] != CW'(DEPTH));
  assign msg3.ready = (cnt_q[1] != CW'(DEPTH));
  assign msg1_count = cnt_q[0];
  assign msg3_count = cnt_q[1];

  // Grant selection and lock FSM; a stalled presentation keeps its grant.
  always_comb begin
    nonempty    = {cnt_q[1] != '0, cnt_q[0] != '0};
    out_valid_i = |nonempty;
    grant       = 1'b0;
    if (state_q == ARB_HELD) begin
      grant = grant_q;
    end else begin
      case (nonempty)
        2'b01:   grant = 1'b0;
        2'b10:   grant = 1'b1;
        2'b11:   grant = (starve_q != 8'(STARVE_LIMIT));
        default: grant = 1'b0;
      endcase
    end
    handshake = out_valid_i && out.ready;
    grant_d   = grant;
    state_d   = state_q;
    case (state_q)
      ARB_OPEN: if (out_valid_i && !out.ready) state_d = ARB_HELD;
      ARB_HELD: if (handshake) state_d = ARB_OPEN;
      default:  state_d = ARB_OPEN;
    endcase
  end

  // Present the granted head; all-zero when nothing is buffered.
  always_comb begin
    out.valid = out_valid_i;
    out_chan  = out_valid_i & grant;
    {out.msg_type, out.data, out.tag, out.source} =
      out_valid_i ? mem_q[grant][rp_q[grant]] : '0;
  end

  // FIFO pointer, count and storage update for both channels.
  always_comb begin
    push  = in_valid & {msg3.ready, msg1.ready};
    pop   = {handshake & grant, handshake & ~grant};
    mem_d = mem_q;
    for (int unsigned c = 0; c < 2; c++) begin
      wp_d[c]  = wp_q[c];
      rp_d[c]  = rp_q[c];
      cnt_d[c] = cnt_q[c];
      if (push[c]) begin
        mem_d[c][wp_q[c]] = in_ent[c];
        wp_d[c]           = wp_q[c] + 1'b1;
      end
      if (pop[c]) rp_d[c] = rp_q[c] + 1'b1;
      case ({push[c], pop[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
        2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

  // Starvation counter: counts response wins over a waiting request.
  always_comb begin
    starve_d = starve_q;
    if (!nonempty[0] || pop[0]) begin
      starve_d = '0;
    end else if (pop[1] && (starve_q < 8'(STARVE_LIMIT))) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // State registers; reset discards all buffered messages.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_OPEN;
      grant_q  <= 1'b0;
      starve_q <= '0;
      for (int unsigned c = 0; c < 2; c++) begin
        wp_q[c]  <= '0;
        rp_q[c]  <= '0;
        cnt_q[c] <= '0;
        for (int unsigned e = 0; e < DEPTH; e++) mem_q[c][e] <= '0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end
endmodule
